// File: rtl/tx_vc_sched_pkg.sv
// Shared types and helpers for the transmit VC scheduler.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic ARB_RR   = 1'b0;
  localparam logic ARB_PRIO = 1'b1;

  // Width of the VC index for a given number of channels.
  function automatic int vc_w_of(input int num_vc);
    return $clog2(num_vc);
  endfunction

endpackage

// File: rtl/tx_vc_sched_if.sv
// Word-stream bundle: push side from the input FIFO, pop side to the
// destination FIFOs, plus per-VC downstream backpressure.
interface tx_vc_sched_if #(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 2
);
  import tx_pkg::*;

  localparam int VC_W = vc_w_of(NUM_VC);

  logic              PUSH;
  logic [DATA_W-1:0] DATA_IN;
  logic [NUM_VC-1:0] DOWN_PAUSE;
  logic [DATA_W-1:0] DATA_OUT;
  logic              VALID_OUT;
  logic [VC_W-1:0]   VC_OUT;

  modport master (
    output PUSH, DATA_IN, DOWN_PAUSE,
    input  DATA_OUT, VALID_OUT, VC_OUT
  );

  modport slave (
    input  PUSH, DATA_IN, DOWN_PAUSE,
    output DATA_OUT, VALID_OUT, VC_OUT
  );

endinterface

// File: rtl/tx_vc_sched_vc_fifo.sv
// Single-VC FIFO with occupancy count. A push into a full FIFO is only
// accepted when a pop happens on the same edge.
module vc_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_l || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/tx_vc_sched.sv
// Transmit VC scheduler: steers pushed words into per-VC FIFOs by their
// top bits and drains them through a round-robin or strict-priority arbiter.
//
// state  | meaning
// RESET  | held in reset, leaves on first edge with RESET_L high
// INIT   | latching thresholds while init=1, FIFOs held empty
// IDLE   | all FIFOs empty, waiting for a push
// ACTIVE | words buffered or arriving, arbiter draining
// ERROR  | overflow seen; no pushes or pops until init
module tx_vc_sched
  import tx_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    RESET_L,
  input  logic                    init,
  input  logic [NUM_VC*CNT_W-1:0] VC_LOW,
  input  logic [NUM_VC*CNT_W-1:0] VC_HIGH,
  input  logic                    ARB_MODE,
  tx_vc_sched_if.slave            bus,
  output logic [NUM_VC-1:0]       PAUSE,
  output logic [NUM_VC-1:0]       ALMOST_EMPTY,
  output logic                    ERROR,
  output logic                    IDLE,
  output logic [2:0]              STATE
);

  localparam int VC_W = vc_w_of(NUM_VC);

  state_t            state;
  logic [CNT_W-1:0]  lo_thr  [NUM_VC];
  logic [CNT_W-1:0]  hi_thr  [NUM_VC];
  logic [CNT_W-1:0]  lo_nxt  [NUM_VC];
  logic [CNT_W-1:0]  hi_nxt  [NUM_VC];
  logic [CNT_W-1:0]  f_count [NUM_VC];
  logic [CNT_W-1:0]  cnt_nxt [NUM_VC];
  logic [DATA_W-1:0] f_data  [NUM_VC];
  logic [NUM_VC-1:0] f_push, f_pop, f_full, f_empty, eligible;
  logic [VC_W-1:0]   rr_ptr, gnt_vc, idx, push_vc;
  logic              gnt_valid, op_ok, flush, overflow, all_empty_nxt;

  assign STATE   = state;
  assign push_vc = bus.DATA_IN[DATA_W-1 -: VC_W];
  assign op_ok   = (state == ST_IDLE || state == ST_ACTIVE) && !init;
  // init out of IDLE/ACTIVE/ERROR flushes on the same edge it is seen.
  assign flush   = (state == ST_INIT) ||
                   (init && (state == ST_IDLE || state == ST_ACTIVE || state == ST_ERROR));
  assign overflow = op_ok && bus.PUSH && f_full[push_vc] && !f_pop[push_vc];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign eligible[v] = op_ok && !f_empty[v] && !bus.DOWN_PAUSE[v];
    assign f_pop[v]    = gnt_valid && (gnt_vc == VC_W'(v));
    assign f_push[v]   = op_ok && bus.PUSH && (push_vc == VC_W'(v)) &&
                         (!f_full[v] || f_pop[v]);

    vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_l   (RESET_L),
      .flush   (flush),
      .push    (f_push[v]),
      .pop     (f_pop[v]),
      .wr_data (bus.DATA_IN),
      .rd_data (f_data[v]),
      .count   (f_count[v]),
      .full    (f_full[v]),
      .empty   (f_empty[v])
    );
  end

  // Grant search: from the pointer in round-robin, from index 0 in priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_vc    = '0;
    idx       = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (ARB_MODE == ARB_PRIO) ? VC_W'(i) : rr_ptr + VC_W'(i);
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_vc    = idx;
      end
    end
  end

  // Post-edge occupancy and thresholds, so the flags track them directly.
  always_comb begin
    all_empty_nxt = 1'b1;
    for (int v = 0; v < NUM_VC; v++) begin
      cnt_nxt[v] = flush ? '0 : f_count[v] + CNT_W'(f_push[v]) - CNT_W'(f_pop[v]);
      if (cnt_nxt[v] != '0) all_empty_nxt = 1'b0;
      if (state == ST_INIT && init) begin
        lo_nxt[v] = VC_LOW[v*CNT_W +: CNT_W];
        hi_nxt[v] = VC_HIGH[v*CNT_W +: CNT_W];
      end else begin
        lo_nxt[v] = lo_thr[v];
        hi_nxt[v] = hi_thr[v];
      end
    end
  end

  // Control FSM with registered IDLE/ERROR outputs.
  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      state <= ST_RESET;
      ERROR <= 1'b0;
      IDLE  <= 1'b0;
    end else begin
      IDLE <= 1'b0;
      case (state)
        ST_RESET: begin
          state <= ST_INIT;
          ERROR <= 1'b0;
        end
        ST_INIT: begin
          if (!init) begin
            state <= ST_IDLE;
            IDLE  <= 1'b1;
          end
        end
        ST_IDLE, ST_ACTIVE: begin
          if (init) begin
            state <= ST_INIT;
            ERROR <= 1'b0;
          end else if (overflow) begin
            state <= ST_ERROR;
            ERROR <= 1'b1;
          end else if (bus.PUSH || !all_empty_nxt) begin
            state <= ST_ACTIVE;
          end else begin
            state <= ST_IDLE;
            IDLE  <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (init) begin
            state <= ST_INIT;
            ERROR <= 1'b0;
          end
        end
        default: begin
          state <= ST_RESET;
          ERROR <= 1'b0;
        end
      endcase
    end
  end

  // Thresholds, arbiter pointer, output word and occupancy flags.
  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      rr_ptr        <= '0;
      bus.DATA_OUT  <= '0;
      bus.VALID_OUT <= 1'b0;
      bus.VC_OUT    <= '0;
      PAUSE         <= '0;
      ALMOST_EMPTY  <= '1;
      for (int v = 0; v < NUM_VC; v++) begin
        lo_thr[v] <= '0;
        hi_thr[v] <= '0;
      end
    end else begin
      bus.VALID_OUT <= gnt_valid;
      if (gnt_valid) begin
        bus.DATA_OUT <= f_data[gnt_vc];
        bus.VC_OUT   <= gnt_vc;
        if (ARB_MODE == ARB_RR) rr_ptr <= gnt_vc + VC_W'(1);
      end
      for (int v = 0; v < NUM_VC; v++) begin
        lo_thr[v]       <= lo_nxt[v];
        hi_thr[v]       <= hi_nxt[v];
        PAUSE[v]        <= (cnt_nxt[v] >= hi_nxt[v]);
        ALMOST_EMPTY[v] <= (cnt_nxt[v] <= lo_nxt[v]);
      end
    end
  end

endmodule

// File: tb/tb_tx_vc_sched.sv
// Bench for tx_vc_sched: queue-based reference model compared every cycle,
// plus directed checks against hand-computed values.
module tb_tx_vc_sched;

  localparam int DATA_W = 6;
  localparam int NUM_VC = 2;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  logic                    clk = 1'b0;
  logic                    RESET_L;
  logic                    init;
  logic [NUM_VC*CNT_W-1:0] VC_LOW, VC_HIGH;
  logic                    ARB_MODE;
  logic [NUM_VC-1:0]       PAUSE, ALMOST_EMPTY;
  logic                    ERROR, IDLE;
  logic [2:0]              STATE;

  tx_vc_sched_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC)) bus ();

  tx_vc_sched #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .RESET_L      (RESET_L),
    .init         (init),
    .VC_LOW       (VC_LOW),
    .VC_HIGH      (VC_HIGH),
    .ARB_MODE     (ARB_MODE),
    .bus          (bus),
    .PAUSE        (PAUSE),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .ERROR        (ERROR),
    .IDLE         (IDLE),
    .STATE        (STATE)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [NUM_VC][$];
  int                m_lo [NUM_VC];
  int                m_hi [NUM_VC];
  int                m_state, m_rr;
  logic [DATA_W-1:0] m_dout;
  logic              m_valid, m_vcout, m_err, m_idle, m_live = 1'b0;
  logic [NUM_VC-1:0] m_pause, m_ae;

  task automatic m_flush();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
  endtask

  always @(posedge clk) begin : model
    int nst, win, pv, vv;
    bit ovf, any;
    if (!RESET_L) begin
      m_flush();
      for (int v = 0; v < NUM_VC; v++) begin m_lo[v] = 0; m_hi[v] = 0; end
      m_state = S_RESET; m_rr = 0; m_dout = '0; m_valid = 0; m_vcout = 0;
      m_pause = '0; m_ae = '1; m_err = 0; m_idle = 0; m_live = 1'b1;
    end else begin
      m_valid = 0;
      nst = m_state;
      case (m_state)
        S_RESET: nst = S_INIT;
        S_INIT: begin
          m_flush();
          if (init) begin
            for (int v = 0; v < NUM_VC; v++) begin
              m_lo[v] = int'(VC_LOW[v*CNT_W +: CNT_W]);
              m_hi[v] = int'(VC_HIGH[v*CNT_W +: CNT_W]);
            end
            nst = S_INIT;
          end else nst = S_IDLE;
        end
        S_IDLE, S_ACTIVE: begin
          if (init) begin
            m_flush(); nst = S_INIT;
          end else begin
            win = -1;
            for (int i = 0; i < NUM_VC; i++) begin
              vv = ARB_MODE ? i : (m_rr + i) % NUM_VC;
              if (win < 0 && mq[vv].size() > 0 && !bus.DOWN_PAUSE[vv]) win = vv;
            end
            if (win >= 0) begin
              m_dout = mq[win].pop_front();
              m_vcout = win[0];
              m_valid = 1;
              if (!ARB_MODE) m_rr = (win + 1) % NUM_VC;
            end
            ovf = 0;
            if (bus.PUSH) begin
              pv = int'(bus.DATA_IN[DATA_W-1]);
              if (mq[pv].size() == DEPTH) ovf = 1;
              else mq[pv].push_back(bus.DATA_IN);
            end
            any = 0;
            for (int v = 0; v < NUM_VC; v++) if (mq[v].size() != 0) any = 1;
            if (ovf) nst = S_ERROR;
            else if (bus.PUSH || any) nst = S_ACTIVE;
            else nst = S_IDLE;
          end
        end
        S_ERROR: if (init) begin m_flush(); nst = S_INIT; end
        default: nst = S_RESET;
      endcase
      m_state = nst;
      m_err   = (nst == S_ERROR);
      m_idle  = (nst == S_IDLE);
      for (int v = 0; v < NUM_VC; v++) begin
        m_pause[v] = (mq[v].size() >= m_hi[v]);
        m_ae[v]    = (mq[v].size() <= m_lo[v]);
      end
    end
  end

  // ---------------- per-cycle compare and output log ----------------
  logic [DATA_W-1:0] out_log [$];

  always @(negedge clk) begin
    logic [16:0] got, exp;
    if (m_live) begin
      got = {bus.DATA_OUT, bus.VALID_OUT, bus.VC_OUT, PAUSE, ALMOST_EMPTY, ERROR, IDLE, STATE};
      exp = {m_dout, m_valid, m_vcout, m_pause, m_ae, m_err, m_idle, 3'(m_state)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle t=%0t dout=%h/%h valid=%b/%b vc=%b/%b pause=%b/%b ae=%b/%b err=%b/%b idle=%b/%b state=%0d/%0d (got/exp)",
                 $time, bus.DATA_OUT, m_dout, bus.VALID_OUT, m_valid, bus.VC_OUT, m_vcout,
                 PAUSE, m_pause, ALMOST_EMPTY, m_ae, ERROR, m_err, IDLE, m_idle, STATE, m_state);
      end
      if (bus.VALID_OUT === 1'b1) out_log.push_back(bus.DATA_OUT);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    bus.PUSH = 1'b1; bus.DATA_IN = w; tick(); bus.PUSH = 1'b0;
  endtask

  task automatic reset_init(input logic [NUM_VC*CNT_W-1:0] lo, input logic [NUM_VC*CNT_W-1:0] hi);
    RESET_L = 1'b0; init = 1'b0; bus.PUSH = 1'b0; tick();
    RESET_L = 1'b1; init = 1'b1; VC_LOW = lo; VC_HIGH = hi;
    tick(); tick();
    init = 1'b0; tick();
  endtask

  task automatic check_seq(input string nm, input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                           input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3);
    logic [DATA_W-1:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_len"}, out_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_%0d", nm, i), (i < out_log.size()) ? out_log[i] : 'x, e[i]);
  endtask

  initial begin
    RESET_L = 1'b0; init = 1'b0; ARB_MODE = 1'b0; VC_LOW = '0; VC_HIGH = '0;
    bus.PUSH = 1'b0; bus.DATA_IN = '0; bus.DOWN_PAUSE = '0;
    tick(); tick();

    // Reset values
    chk("rst_state", STATE, S_RESET);
    chk("rst_valid", bus.VALID_OUT, 0);
    chk("rst_dout", bus.DATA_OUT, 0);
    chk("rst_ae", ALMOST_EMPTY, 2'b11);
    chk("rst_pause", PAUSE, 0);
    chk("rst_err", ERROR, 0);

    // 1: init sequence
    RESET_L = 1'b1; init = 1'b1; VC_LOW = {5'd1, 5'd1}; VC_HIGH = {5'd3, 5'd3};
    tick();
    chk("t1_init", STATE, S_INIT);
    tick();
    init = 1'b0; tick();
    chk("t1_idle_state", STATE, S_IDLE);
    chk("t1_idle_flag", IDLE, 1);
    chk("t1_ae", ALMOST_EMPTY, 2'b11);
    chk("t1_pause", PAUSE, 2'b00);

    // 2: single word latency
    push_word(6'h05);
    chk("t2_active", STATE, S_ACTIVE);
    chk("t2_no_bypass", bus.VALID_OUT, 0);
    tick();
    chk("t2_valid", bus.VALID_OUT, 1);
    chk("t2_dout", bus.DATA_OUT, 6'h05);
    chk("t2_vc", bus.VC_OUT, 0);
    tick();
    chk("t2_valid_drop", bus.VALID_OUT, 0);
    chk("t2_back_idle", STATE, S_IDLE);

    // 3: round-robin then strict priority on the same preload
    reset_init({5'd1, 5'd1}, {5'd3, 5'd3});
    bus.DOWN_PAUSE = 2'b11; ARB_MODE = 1'b0;
    push_word(6'h01); push_word(6'h02); push_word(6'h21); push_word(6'h22);
    bus.DOWN_PAUSE = 2'b00; out_log.delete();
    repeat (5) tick();
    check_seq("t3_rr", 6'h01, 6'h21, 6'h02, 6'h22);

    bus.DOWN_PAUSE = 2'b11; ARB_MODE = 1'b1;
    push_word(6'h01); push_word(6'h02); push_word(6'h21); push_word(6'h22);
    bus.DOWN_PAUSE = 2'b00; out_log.delete();
    repeat (5) tick();
    check_seq("t3_prio", 6'h01, 6'h02, 6'h21, 6'h22);
    chk("t3_idle", STATE, S_IDLE);

    // 4: pause threshold, then overflow
    ARB_MODE = 1'b0; bus.DOWN_PAUSE = 2'b01;
    push_word(6'h0A); push_word(6'h0B); push_word(6'h0C);
    chk("t4_pause0", PAUSE[0], 1);
    chk("t4_ae0", ALMOST_EMPTY[0], 0);
    for (int i = 0; i < 16; i++) push_word(6'h10 + 6'(i));
    chk("t4_err", ERROR, 1);
    chk("t4_state", STATE, S_ERROR);
    chk("t4_valid", bus.VALID_OUT, 0);
    bus.DOWN_PAUSE = 2'b00; tick(); tick();
    chk("t4_no_pop", bus.VALID_OUT, 0);
    chk("t4_hold_err", STATE, S_ERROR);

    // 5: init recovers from ERROR
    init = 1'b1; VC_LOW = {5'd15, 5'd1}; VC_HIGH = {5'd16, 5'd3};
    tick();
    chk("t5_state", STATE, S_INIT);
    chk("t5_err", ERROR, 0);
    chk("t5_ae", ALMOST_EMPTY, 2'b11);
    tick();
    init = 1'b0; tick();
    chk("t5_idle", STATE, S_IDLE);

    // 6: fill VC1, push while popping at full, then reset mid-stream
    bus.DOWN_PAUSE = 2'b10;
    for (int i = 0; i < 16; i++) push_word(6'h20 + 6'(i));
    chk("t6_full_pause", PAUSE, 2'b10);
    chk("t6_full_ae", ALMOST_EMPTY, 2'b01);
    chk("t6_full_err", ERROR, 0);
    bus.DOWN_PAUSE = 2'b00;
    push_word(6'h3F);
    chk("t6_same_edge_err", ERROR, 0);
    chk("t6_same_edge_valid", bus.VALID_OUT, 1);
    chk("t6_same_edge_dout", bus.DATA_OUT, 6'h20);
    chk("t6_same_edge_vc", bus.VC_OUT, 1);
    chk("t6_still_full", PAUSE[1], 1);
    chk("t6_state", STATE, S_ACTIVE);
    bus.PUSH = 1'b1; bus.DATA_IN = 6'h31;
    tick(); tick();
    RESET_L = 1'b0; tick();
    chk("t6_rst_state", STATE, S_RESET);
    chk("t6_rst_valid", bus.VALID_OUT, 0);
    chk("t6_rst_dout", bus.DATA_OUT, 0);
    chk("t6_rst_vc", bus.VC_OUT, 0);
    chk("t6_rst_pause", PAUSE, 0);
    chk("t6_rst_ae", ALMOST_EMPTY, 2'b11);
    chk("t6_rst_err", ERROR, 0);
    chk("t6_rst_idle", IDLE, 0);
    bus.PUSH = 1'b0; RESET_L = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_vc_sched.md
Name: tx_vc_sched

Overview:
- Parametrised next-generation transmit scheduler: accepts one pushed word stream, steers each word by its VC field into one of NUM_VC internal FIFOs and drains them onto a single output through a selectable arbiter.
- Per-VC programmable low/high thresholds drive almost-empty and pause flags, and an init/idle/active/error state machine controls the whole block.
- Sits between the main input FIFO and the destination FIFOs of the transmit path.

Parameters:
DATA_W, 6, word width; the VC field is the top VC_W bits, and VC_W = log2(NUM_VC).
NUM_VC, 2, number of virtual channels; must be a power of 2 and at least 2.
DEPTH, 16, words per VC FIFO; must be a power of 2.
CNT_W, 5, occupancy/threshold width, equal to log2(DEPTH)+1.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
RESET_L  in  1  synchronous, active-low reset.
init  in  1  threshold-load / flush request.
PUSH  in  1  write DATA_IN this cycle.
DATA_IN  in  DATA_W  input word; bits [DATA_W-1 -: VC_W] select the VC.
VC_LOW  in  NUM_VC*CNT_W  per-VC almost-empty thresholds; VC v uses slice v.
VC_HIGH  in  NUM_VC*CNT_W  per-VC pause thresholds.
ARB_MODE  in  1  0 = round-robin, 1 = strict priority (lowest index wins).
DOWN_PAUSE  in  NUM_VC  downstream backpressure; VC v is not eligible while bit v is high.
DATA_OUT  out  DATA_W  registered output word.
VALID_OUT  out  1  DATA_OUT is valid this cycle.
VC_OUT  out  VC_W  VC index of DATA_OUT.
PAUSE  out  NUM_VC  bit v = occupancy[v] >= high_thr[v].
ALMOST_EMPTY  out  NUM_VC  bit v = occupancy[v] <= low_thr[v].
ERROR  out  1  sticky overflow flag.
IDLE  out  1  high in state IDLE.
STATE  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (RESET_L low at edge):
  - Outputs: DATA_OUT=0, VALID_OUT=0, VC_OUT=0, PAUSE=0, ALMOST_EMPTY=all 1, ERROR=0, IDLE=0, STATE=RESET.
  - Internal: FIFOs empty, thresholds 0, round-robin pointer 0.
  - Reset mid-operation discards all contents.
- FSM states are RESET, INIT, IDLE, ACTIVE, ERROR.
  - RESET goes to INIT on the first edge with RESET_L high.
  - INIT: latches VC_LOW/VC_HIGH on every edge while init=1; FIFOs are held empty; PUSH is ignored. Goes to IDLE on the first edge with init=0.
  - IDLE: all FIFOs empty. Goes to ACTIVE on PUSH.
  - ACTIVE goes back to IDLE when all FIFOs are empty after the edge and no PUSH occurred.
  - Any of IDLE or ACTIVE goes to ERROR on an overflow.
  - init=1 in IDLE, ACTIVE or ERROR goes to INIT, flushes the FIFOs and clears ERROR.
- Push:
  - A push is sampled at edge k and written to the FIFO named by its VC field.
  - Push to a full FIFO: the word is dropped, ERROR=1 from edge k+1, state becomes ERROR.
  - In ERROR, pushes are ignored and no pops occur (VALID_OUT=0). Contents are retained until init or reset.
- Pop/arbitration (states IDLE/ACTIVE only):
  - Eligible VC: non-empty and DOWN_PAUSE[v]=0.
  - At each edge, one eligible VC is popped into DATA_OUT/VC_OUT and VALID_OUT=1; with no eligible VC, VALID_OUT=0 and DATA_OUT holds its value.
  - Round-robin: search starts at the pointer; after a grant, pointer = winner+1 mod NUM_VC. Pointer is unchanged when there is no grant.
  - Strict priority: lowest eligible index wins; the pointer is not updated.
- Latency: a word pushed at edge k into an empty, eligible VC appears with VALID_OUT=1 after edge k+1. There is no bypass path.
- Simultaneous push and pop on the same VC: occupancy is unchanged. A push into a full VC that is popped on the same edge is accepted and is not an overflow.
- Counts and flags:
  - Occupancy per VC is 0..DEPTH, CNT_W bits; read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - PAUSE and ALMOST_EMPTY are registered and reflect occupancy after each edge.
  - A threshold above DEPTH means PAUSE for that VC never asserts.

Decomposition:
- Package tx_pkg holds: FSM state encoding (RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4), the ARB_MODE constants, and a VC_W derivation function.
- Sub-module vc_fifo (DATA_W, DEPTH) is instantiated NUM_VC times via generate. It provides push, pop, data, occupancy, full and empty.
- The arbiter and FSM live in tx_vc_sched.

Test Plan:
1. Reset, then init=1 for 2 cycles with VC_LOW={1,1} and VC_HIGH={3,3}, then init=0 -> STATE goes INIT then IDLE, ALMOST_EMPTY=2'b11, PAUSE=0.
2. Push 0x05 (VC0), wait -> after edge k+1: VALID_OUT=1, DATA_OUT=0x05, VC_OUT=0; next cycle VALID_OUT=0 and state returns to IDLE.
3. Round-robin with DOWN_PAUSE=2'b11 preload: push 0x01, 0x02 (VC0) and 0x21, 0x22 (VC1), then release DOWN_PAUSE -> output sequence 0x01, 0x21, 0x02, 0x22; with ARB_MODE=1 the same preload outputs 0x01, 0x02, 0x21, 0x22.
4. DOWN_PAUSE[0]=1 and push 3 words to VC0 -> PAUSE[0]=1 after the third push and ALMOST_EMPTY[0]=0; pushing 16 more words overflows -> ERROR=1, state ERROR, VALID_OUT=0.
5. In ERROR, assert init=1 -> state INIT, ERROR=0, all FIFOs empty, ALMOST_EMPTY=all 1.
6. VC1 full with DOWN_PAUSE=0, push to VC1 on the same edge it is popped -> no ERROR and occupancy stays 16. Assert RESET_L=0 mid-stream -> all outputs return to their reset values after the edge.
